// File: rtl/serdesphy_pkg.sv
// serdesphy_pkg: shared PRBS7 definitions for the SerDes PHY RX checker and TX generator.
//   - prbs_state_t : checker state encoding (IDLE, SEED, HUNT, LOCKED)
//   - PRBS7_LEN    : LFSR length
//   - PRBS7_TAP_A/B: feedback taps for x^7 + x^6 + 1
package serdesphy_pkg;

  localparam int unsigned PRBS7_LEN   = 7;
  localparam int unsigned PRBS7_TAP_A = 6;
  localparam int unsigned PRBS7_TAP_B = 5;

  typedef enum logic [1:0] {
    PRBS_IDLE   = 2'd0,
    PRBS_SEED   = 2'd1,
    PRBS_HUNT   = 2'd2,
    PRBS_LOCKED = 2'd3
  } prbs_state_t;

endpackage

// File: rtl/serdesphy_prbs7_gen.sv
// serdesphy_prbs7_gen: PRBS7 LFSR register shared by the RX checker and TX generator.
// Ports:
//   clk, rst_n    : clock, async active-low reset (LFSR clears to 0)
//   load_i        : load load_val_i (has priority over shifting)
//   load_val_i    : value loaded on load_i
//   shift_en_i    : shift one position this cycle
//   fb_sel_i      : 1 = shift in own prediction (free-run), 0 = shift in bit_i
//   bit_i         : external shift-in bit
//   lfsr_o        : current LFSR contents
//   pred_c_o      : combinational predicted next bit s[6]^s[5]
module serdesphy_prbs7_gen
  import serdesphy_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_i,
  input  logic [PRBS7_LEN-1:0] load_val_i,
  input  logic                 shift_en_i,
  input  logic                 fb_sel_i,
  input  logic                 bit_i,
  output logic [PRBS7_LEN-1:0] lfsr_o,
  output logic                 pred_c_o
);

  logic [PRBS7_LEN-1:0] lfsr_q, lfsr_d;

  assign pred_c_o = lfsr_q[PRBS7_TAP_A] ^ lfsr_q[PRBS7_TAP_B];
  assign lfsr_o   = lfsr_q;

  // Next LFSR value: load wins over shift.
  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = load_val_i;
    end else if (shift_en_i) begin
      lfsr_d = {lfsr_q[PRBS7_LEN-2:0], (fb_sel_i ? pred_c_o : bit_i)};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= '0;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/serdesphy_prbs_chk.sv
// serdesphy_prbs_chk: self-synchronising PRBS7 (x^7+x^6+1) checker for the SerDes RX path.
// Ports:
//   clk, rst_n    : clock, async active-low reset
//   chk_en        : checker enable (level, sampled every cycle)
//   rx_bit        : recovered data bit
//   rx_bit_valid  : rx_bit qualifier
//   clr_err       : pulse clearing err_cnt (wins over a same-cycle increment)
//   prbs_lock     : checker locked (registered)
//   prbs_err      : one-cycle pulse per bit error while locked (registered)
//   err_cnt       : saturating error count (registered)
// Build option: define SERDESPHY_PRBS_ERR_CNT_EN to build the error counter;
// otherwise err_cnt is tied to 0 and clr_err is ignored.
module serdesphy_prbs_chk
  import serdesphy_pkg::*;
#(
  parameter int unsigned LOCK_MATCHES = 16,
  parameter int unsigned UNLOCK_ERRS  = 4,
  parameter int unsigned ERR_WIN      = 64,
  parameter int unsigned ERR_CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 chk_en,
  input  logic                 rx_bit,
  input  logic                 rx_bit_valid,
  input  logic                 clr_err,
  output logic                 prbs_lock,
  output logic                 prbs_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int unsigned SEED_W  = $clog2(PRBS7_LEN);
  localparam int unsigned MATCH_W = 8;
  localparam int unsigned WIN_W   = $clog2(ERR_WIN);
  localparam int unsigned WERR_W  = $clog2(ERR_WIN + 1);

  localparam logic [1:0] S_IDLE   = PRBS_IDLE;
  localparam logic [1:0] S_SEED   = PRBS_SEED;
  localparam logic [1:0] S_HUNT   = PRBS_HUNT;
  localparam logic [1:0] S_LOCKED = PRBS_LOCKED;

  logic [1:0]         state_q, state_d;
  logic [SEED_W-1:0]  seed_cnt_q, seed_cnt_d;
  logic [MATCH_W-1:0] match_cnt_q, match_cnt_d;
  logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
  logic [WERR_W-1:0]  win_err_q, win_err_d;
  logic               lock_q, lock_d;
  logic               err_q, err_d;
  logic               err_inc;

  logic                 lfsr_load, lfsr_shift, lfsr_fb;
  logic [PRBS7_LEN-1:0] lfsr;
  logic                 pred;
  logic                 mismatch;
  logic [PRBS7_LEN-1:0] seed_next;
  logic [WERR_W-1:0]    werr_sum;
  logic                 unused_lfsr_msb;

  serdesphy_prbs7_gen u_lfsr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (lfsr_load),
    .load_val_i ('0),
    .shift_en_i (lfsr_shift),
    .fb_sel_i   (lfsr_fb),
    .bit_i      (rx_bit),
    .lfsr_o     (lfsr),
    .pred_c_o   (pred)
  );

  assign mismatch        = rx_bit ^ pred;
  assign seed_next       = {lfsr[PRBS7_LEN-2:0], rx_bit};
  assign werr_sum        = win_err_q + WERR_W'(mismatch);
  assign unused_lfsr_msb = lfsr[PRBS7_LEN-1];

  // Next-state, counters and LFSR control.
  always_comb begin
    state_d     = state_q;
    seed_cnt_d  = seed_cnt_q;
    match_cnt_d = match_cnt_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    lock_d      = lock_q;
    err_d       = 1'b0;
    err_inc     = 1'b0;
    lfsr_load   = 1'b0;
    lfsr_shift  = 1'b0;
    lfsr_fb     = 1'b0;

    if (!chk_en) begin
      state_d     = S_IDLE;
      lock_d      = 1'b0;
      seed_cnt_d  = '0;
      match_cnt_d = '0;
      win_cnt_d   = '0;
      win_err_d   = '0;
      lfsr_load   = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d    = S_SEED;
          seed_cnt_d = '0;
        end
        S_SEED: begin
          if (rx_bit_valid) begin
            lfsr_shift = 1'b1;
            if (seed_cnt_q == SEED_W'(PRBS7_LEN - 1)) begin
              seed_cnt_d = '0;
              // An all-zero seed is the LFSR lock-up state: keep seeding.
              if (seed_next != '0) begin
                state_d     = S_HUNT;
                match_cnt_d = '0;
              end
            end else begin
              seed_cnt_d = seed_cnt_q + SEED_W'(1);
            end
          end
        end
        S_HUNT: begin
          if (rx_bit_valid) begin
            lfsr_shift = 1'b1;
            if (mismatch) begin
              state_d    = S_SEED;
              seed_cnt_d = '0;
            end else if (match_cnt_q == MATCH_W'(LOCK_MATCHES - 1)) begin
              state_d     = S_LOCKED;
              lock_d      = 1'b1;
              match_cnt_d = '0;
              win_cnt_d   = '0;
              win_err_d   = '0;
            end else begin
              match_cnt_d = match_cnt_q + MATCH_W'(1);
            end
          end
        end
        S_LOCKED: begin
          if (rx_bit_valid) begin
            // Free-run on the prediction so a bad bit does not corrupt the LFSR.
            lfsr_shift = 1'b1;
            lfsr_fb    = 1'b1;
            err_d      = mismatch;
            err_inc    = mismatch;
            if (32'(werr_sum) >= UNLOCK_ERRS) begin
              state_d    = S_SEED;
              lock_d     = 1'b0;
              seed_cnt_d = '0;
            end else begin
              win_cnt_d = win_cnt_q + WIN_W'(1);
              win_err_d = (win_cnt_q == WIN_W'(ERR_WIN - 1)) ? WERR_W'(mismatch) : werr_sum;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      seed_cnt_q  <= '0;
      match_cnt_q <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      lock_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      seed_cnt_q  <= seed_cnt_d;
      match_cnt_q <= match_cnt_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      lock_q      <= lock_d;
      err_q       <= err_d;
    end
  end

  assign prbs_lock = lock_q;
  assign prbs_err  = err_q;

`ifdef SERDESPHY_PRBS_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Saturating error counter; clear wins over a same-cycle increment.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (clr_err) begin
      err_cnt_d = '0;
    end else if (err_inc && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  logic unused_cnt_in;
  assign unused_cnt_in = clr_err ^ err_inc;
  assign err_cnt       = '0;
`endif

endmodule
